muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// HI/LO unit sequencer: MULT/MULTU/DIV/DIVU on one shared 32-step shift/add-subtract
// datapath, owning the HI/LO registers and the MTHI/MTLO write path.
module muldiv_seq #(
  parameter int unsigned ITER   = 32,
  parameter int unsigned DZ_LAT = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] mt_data,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_mag;
  logic [W-1:0]    r_ph;
  logic [W-1:0]    r_pl;
  logic            r_sign_q;
  logic            r_sign_r;
  logic            r_dz;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_res_hi;
  logic [W-1:0]    r_res_lo;
  logic            r_busy;
  logic            r_done;
  logic            r_div_zero;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic            w_is_div;
  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic [W:0]      w_add;
  logic [W:0]      w_shift;
  logic [W:0]      w_diff;
  logic [2*W-1:0]  w_prod;
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;

  // Operand conditioning on the latched operands (used in PREP)
  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_neg_a  = w_signed & r_a[W-1];
  assign w_neg_b  = w_signed & r_b[W-1];
  assign w_mag_a  = w_neg_a ? (~r_a + W'(1)) : r_a;
  assign w_mag_b  = w_neg_b ? (~r_b + W'(1)) : r_b;

  // One datapath step: multiply adds r_mag into the high half then shifts right;
  // divide shifts the remainder left and trial-subtracts the divisor.
  assign w_add   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mag} : (W+1)'(0));
  assign w_shift = {r_ph, r_pl[W-1]};
  assign w_diff  = w_shift - {1'b0, r_mag};

  // Sign fix-up of the magnitude results
  assign w_prod     = {r_ph, r_pl};
  assign w_prod_fix = r_sign_q ? (~w_prod + (2*W)'(1)) : w_prod;
  assign w_quo_fix  = r_sign_q ? (~r_pl + W'(1)) : r_pl;
  assign w_rem_fix  = r_sign_r ? (~r_ph + W'(1)) : r_ph;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_a        <= '0;
      r_b        <= '0;
      r_mag      <= '0;
      r_ph       <= '0;
      r_pl       <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dz       <= 1'b0;
      r_cnt      <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end else if (!start) begin
            if (mt_hi) r_hi <= mt_data;
            if (mt_lo) r_lo <= mt_data;
          end
        end

        S_PREP: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_ph     <= '0;
            r_cnt    <= '0;
            r_dz     <= w_is_div && (r_b == '0);
            if (w_is_div) begin
              r_pl  <= w_mag_a;
              r_mag <= w_mag_b;
            end else begin
              r_pl  <= w_mag_b;
              r_mag <= w_mag_a;
            end
            // Divide-by-zero bypasses the datapath; extra latency beyond two
            // cycles is burnt as idle RUN cycles at the top of the counter.
            if (w_is_div && (r_b == '0)) begin
              if (DZ_LAT > 2) begin
                r_cnt   <= CW'(ITER - (DZ_LAT - 2));
                r_state <= S_RUN;
              end else begin
                r_state <= S_FIX;
              end
            end else begin
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (!r_dz) begin
              if (w_is_div) begin
                if (!w_diff[W]) begin
                  r_ph <= w_diff[W-1:0];
                  r_pl <= {r_pl[W-2:0], 1'b1};
                end else begin
                  r_ph <= w_shift[W-1:0];
                  r_pl <= {r_pl[W-2:0], 1'b0};
                end
              end else begin
                r_ph <= w_add[W:1];
                r_pl <= {w_add[0], r_pl[W-1:1]};
              end
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_dz) begin
              r_res_hi <= r_a;
              r_res_lo <= '1;
            end else if (w_is_div) begin
              r_res_hi <= w_rem_fix;
              r_res_lo <= w_quo_fix;
            end else begin
              r_res_hi <= w_prod_fix[2*W-1:W];
              r_res_lo <= w_prod_fix[W-1:0];
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        // Committed: a flush here no longer cancels the write
        S_DONE: begin
          r_hi <= r_res_hi;
          r_lo <= r_res_lo;
          if (w_is_div) r_div_zero <= r_dz;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign stall    = start | r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: scoreboard of expected HI/LO/div_zero per accepted
// operation, latency and busy-length checks, flush, reset and MT* interactions.
module tb_muldiv_seq;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_data;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  muldiv_seq #(.ITER(32), .DZ_LAT(2)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mt_hi    (mt_hi),
    .mt_lo    (mt_lo),
    .mt_data  (mt_data),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected result and compare against the written HI/LO
  task automatic retire(input string tag);
    exp_t e;
    check({tag, "_pending"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
      check({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int lat, input bit with_mtlo);
    int n;
    int nbusy;
    sb.push_back('{hi: ehi, lo: elo, dz: edz});
    @(negedge clk_in);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    if (with_mtlo) begin
      mt_lo   = 1'b1;
      mt_data = 32'hDEAD_BEEF;
    end
    #1;
    check({tag, "_stall"}, 64'(stall), 64'd1);
    @(posedge clk_in);
    n = 0;
    nbusy = 0;
    do begin
      @(negedge clk_in);
      if (n == 0) begin
        start = 1'b0;
        mt_lo = 1'b0;
      end
      n++;
      nbusy += int'(busy);
    end while (!done && n < 100);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_busycyc"}, 64'(nbusy), 64'(lat));
    @(posedge clk_in);
    #1;
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    check({tag, "_done_off"}, 64'(done), 64'd0);
    retire(tag);
  endtask

  initial begin
    int n;
    int ndone;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    mt_data = '0;
    flush   = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hilo", 64'({hi, lo}), 64'd0);

    // MTHI and MTLO in the same cycle
    mt_hi = 1'b1;
    mt_lo = 1'b1;
    mt_data = 32'hA5A5_5A5A;
    @(negedge clk_in);
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    check("mt_both", 64'({hi, lo}), 64'hA5A5_5A5A_A5A5_5A5A);

    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100,      32'd7,        32'd2,         32'd14,        1'b0, 35, 1'b0);
    run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 35, 1'b0);
    run_op("div_zero",  2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 3,  1'b0);
    run_op("mult_keepdz", 2'b00, 32'd2,       32'd3,        32'd0,         32'd6,         1'b1, 35, 1'b0);
    run_op("divu_clrdz", 2'b11, 32'd9,        32'd3,        32'd0,         32'd3,         1'b0, 35, 1'b0);

    // MTHI, then flush a MULTU when its counter reaches 10
    @(negedge clk_in);
    mt_hi = 1'b1;
    mt_data = 32'h1234_5678;
    @(negedge clk_in);
    mt_hi = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_lo", 64'(lo), 64'd3);
    start = 1'b1;
    op = 2'b01;
    a = 32'd3;
    b = 32'd4;
    @(posedge clk_in);
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_in);
      if (i == 1) start = 1'b0;
      ndone += int'(done);
    end
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'h1234_5678);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      ndone += int'(done);
    end
    check("flush_nodone", 64'(ndone), 64'd0);

    // start wins over a simultaneous MTLO
    run_op("multu_mtlo", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 35, 1'b1);
    run_op("div_zero2",  2'b10, 32'h11, 32'd0, 32'h11, 32'hFFFF_FFFF, 1'b1, 3, 1'b0);

    // Reset during RUN cycle 20
    @(negedge clk_in);
    start = 1'b1;
    op = 2'b01;
    a = 32'd7;
    b = 32'd9;
    @(posedge clk_in);
    ndone = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk_in);
      if (i == 1) start = 1'b0;
      ndone += int'(done);
    end
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check("rstrun_busy", 64'(busy), 64'd0);
    check("rstrun_hilo", 64'({hi, lo}), 64'd0);
    check("rstrun_dz", 64'(div_zero), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      ndone += int'(done);
    end
    check("rstrun_nodone", 64'(ndone), 64'd0);

    // start held high while busy: one accepted start, one done
    sb.push_back('{hi: 32'd0, lo: 32'd30, dz: 1'b0});
    @(negedge clk_in);
    start = 1'b1;
    op = 2'b01;
    a = 32'd5;
    b = 32'd6;
    ndone = 0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_in);
      if (i == 20) begin
        n = int'(stall);
        start = 1'b0;
      end
      ndone += int'(done);
    end
    check("held_stall", 64'(n), 64'd1);
    check("held_onedone", 64'(ndone), 64'd1);
    retire("held");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
